adc_frame_capture: RTL and testbench

//  Parametrised ADC front-end capture. Registers parallel ADC samples on ad0_clk and waits out a

---
 rtl/adc_cap_pkg.sv | 26 ++
 rtl/adc_sync_detect.sv | 61 ++++++
 rtl/adc_frame_capture.sv | 190 +++++++++++++++++++
 tb/tb_adc_frame_capture.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_cap_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adc_cap_pkg
// Purpose  : Shared types and helpers for the ADC frame capture block.
//            - cap_state_e : capture FSM state encoding
//            - cnt_width() : counter width able to hold the value 'limit'
// Revision : 1.0  initial release
// ============================================================================
package adc_cap_pkg;

  typedef enum logic [2:0] {
    ST_SETTLE  = 3'd0,
    ST_IDLE    = 3'd1,
    ST_HUNT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } cap_state_e;

  // One extra bit over $clog2 so that a counter can represent 'limit' itself,
  // which keeps power-of-two limits from aliasing back to zero.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return $clog2(limit) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc_sync_detect.sv
`default_nettype none
// ============================================================================
// Module   : adc_sync_detect
// Purpose  : Counts consecutive SYNC_WORD samples while enabled and raises a
//            registered one-cycle hit pulse when SYNC_LEN of them are seen.
// Ports    : clk_i   in  1   sample clock
//            rst_ni  in  1   async active-low reset
//            en_i    in  1   hunting enabled (matching is cleared when low)
//            data_i  in  DW  raw sample from the pins
//            hit_o   out 1   registered sync hit pulse
// Revision : 1.0  initial release
// ============================================================================
module adc_sync_detect
  import adc_cap_pkg::*;
#(
  parameter int unsigned DW        = 8,
  parameter int unsigned SYNC_WORD = 209,
  parameter int unsigned SYNC_LEN  = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic [DW-1:0] data_i,
  output logic          hit_o
);

  localparam int unsigned     MW         = cnt_width(SYNC_LEN);
  localparam logic [MW-1:0]   MATCH_LAST = MW'(SYNC_LEN - 1);
  localparam logic [DW-1:0]   SYNC_VAL   = DW'(SYNC_WORD);

  logic [MW-1:0] match_q, match_d;
  logic          hit_q, hit_d;

  // While the hit pulse is high the counter is held at zero so a run of
  // sync words longer than SYNC_LEN cannot produce a second pulse.
  always_comb begin
    match_d = '0;
    hit_d   = 1'b0;
    if (en_i && !hit_q && (data_i == SYNC_VAL)) begin
      if (match_q == MATCH_LAST) begin
        hit_d = 1'b1;
      end else begin
        match_d = match_q + MW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      match_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      match_q <= match_d;
      hit_q   <= hit_d;
    end
  end

  assign hit_o = hit_q;

endmodule
`default_nettype wire

// File: rtl/adc_frame_capture.sv
`default_nettype none
// ============================================================================
// Module   : adc_frame_capture
// Purpose  : ADC front-end capture. Registers every sample, waits out a settle
//            period, hunts for a sync pattern when armed, pulses the FIFO
//            reset, then writes one decimated frame of FRAME_LEN samples.
// Ports    : ad0_clk_i   in  1      sample clock (rising edge)
//            rst_ni      in  1      async active-low reset
//            ad_data_i   in  DW     raw ADC sample
//            arm_i       in  1      request capture of one frame
//            decim_i     in  DEC_W  keep 1 of decim samples (0/1 = all)
//            fifo_full_i in  1      FIFO full flag
//            fifo_rst_o  out 1      active-low FIFO reset pulse on sync hit
//            data_reg_o  out DW     registered sample (FIFO din)
//            wr_en_o     out 1      FIFO write strobe aligned with data_reg_o
//            busy_o      out 1      high while hunting or capturing
//            done_o      out 1      one-cycle frame complete pulse
//            overflow_o  out 1      sticky dropped-sample flag, cleared on arm
// Revision : 1.0  initial release
// ============================================================================
module adc_frame_capture
  import adc_cap_pkg::*;
#(
  parameter int unsigned DW         = 8,
  parameter int unsigned SETTLE_CYC = 5,
  parameter int unsigned SYNC_WORD  = 209,
  parameter int unsigned SYNC_LEN   = 2,
  parameter int unsigned FRAME_LEN  = 1024,
  parameter int unsigned DEC_W      = 8
) (
  input  logic             ad0_clk_i,
  input  logic             rst_ni,
  input  logic [DW-1:0]    ad_data_i,
  input  logic             arm_i,
  input  logic [DEC_W-1:0] decim_i,
  input  logic             fifo_full_i,
  output logic             fifo_rst_o,
  output logic [DW-1:0]    data_reg_o,
  output logic             wr_en_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             overflow_o
);

  localparam int unsigned      SET_W      = cnt_width(SETTLE_CYC);
  localparam int unsigned      FRM_W      = cnt_width(FRAME_LEN);
  localparam logic [SET_W-1:0] SET_LAST   = SET_W'(SETTLE_CYC - 1);
  localparam logic [FRM_W-1:0] FRM_LAST   = FRM_W'(FRAME_LEN - 1);

  cap_state_e       state_q, state_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic [FRM_W-1:0] frame_q, frame_d;
  logic [DEC_W-1:0] phase_q, phase_d;
  logic [DEC_W-1:0] ratio_q, ratio_d;
  logic [DW-1:0]    data_q;
  logic             overflow_q, overflow_d;

  logic             w_hit;
  logic             w_due;
  logic [DEC_W-1:0] w_phase_last;

  // --------------------------------------------------------------------------
  // Sync pattern detection (only active while hunting)
  // --------------------------------------------------------------------------
  adc_sync_detect #(
    .DW        (DW),
    .SYNC_WORD (SYNC_WORD),
    .SYNC_LEN  (SYNC_LEN)
  ) u_sync_detect (
    .clk_i  (ad0_clk_i),
    .rst_ni (rst_ni),
    .en_i   (state_q == ST_HUNT),
    .data_i (ad_data_i),
    .hit_o  (w_hit)
  );

  // Ratios 0 and 1 both mean "every sample", so the phase never leaves 0.
  assign w_phase_last = (ratio_q <= DEC_W'(1)) ? '0 : (ratio_q - DEC_W'(1));
  assign w_due        = (phase_q == '0);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge ad0_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_SETTLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SETTLE:  if (settle_q == SET_LAST)                  state_d = ST_IDLE;
      ST_IDLE:    if (arm_i)                                 state_d = ST_HUNT;
      ST_HUNT:    if (w_hit)                                 state_d = ST_CAPTURE;
      ST_CAPTURE: if (w_due && (frame_q == FRM_LAST))        state_d = ST_DONE;
      ST_DONE:                                               state_d = ST_IDLE;
      default:                                               state_d = ST_SETTLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs (decoded from registered state; the write strobe also looks
  // at fifo_full so it can never coincide with a full FIFO)
  // --------------------------------------------------------------------------
  always_comb begin
    wr_en_o = 1'b0;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      ST_HUNT: begin
        busy_o = 1'b1;
      end
      ST_CAPTURE: begin
        busy_o  = 1'b1;
        wr_en_o = w_due && !fifo_full_i;
      end
      ST_DONE: begin
        done_o = 1'b1;
      end
      default: begin
        busy_o = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath counters
  // --------------------------------------------------------------------------
  always_comb begin
    settle_d   = settle_q;
    frame_d    = frame_q;
    phase_d    = phase_q;
    ratio_d    = ratio_q;
    overflow_d = overflow_q;
    case (state_q)
      ST_SETTLE: begin
        if (settle_q != SET_LAST) settle_d = settle_q + SET_W'(1);
      end
      ST_IDLE: begin
        if (arm_i) overflow_d = 1'b0;
      end
      ST_HUNT: begin
        // Counters are primed here so CAPTURE starts from a clean phase.
        frame_d = '0;
        phase_d = '0;
        if (w_hit) ratio_d = decim_i;
      end
      ST_CAPTURE: begin
        phase_d = (phase_q == w_phase_last) ? '0 : (phase_q + DEC_W'(1));
        if (w_due) begin
          frame_d = frame_q + FRM_W'(1);
          if (fifo_full_i) overflow_d = 1'b1;
        end
      end
      default: begin
        settle_d = settle_q;
      end
    endcase
  end

  always_ff @(posedge ad0_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      settle_q   <= '0;
      frame_q    <= '0;
      phase_q    <= '0;
      ratio_q    <= '0;
      overflow_q <= 1'b0;
      data_q     <= '0;
    end else begin
      settle_q   <= settle_d;
      frame_q    <= frame_d;
      phase_q    <= phase_d;
      ratio_q    <= ratio_d;
      overflow_q <= overflow_d;
      data_q     <= ad_data_i;
    end
  end

  assign data_reg_o = data_q;
  assign overflow_o = overflow_q;
  assign fifo_rst_o = !w_hit;

endmodule
`default_nettype wire

// File: tb/tb_adc_frame_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_adc_frame_capture
// Purpose  : Self-checking bench for adc_frame_capture. Stimulus frames are
//            generated up front, a reference model predicts the written
//            samples into a scoreboard queue, and a monitor compares every
//            FIFO write. A second instance with SYNC_LEN=3 shares the inputs.
// Revision : 1.0  initial release
// ============================================================================
module tb_adc_frame_capture;

  localparam int DW     = 8;
  localparam int SETTLE = 5;
  localparam int SYNC   = 209;
  localparam int FLEN   = 64;
  localparam int FLEN3  = 16;
  localparam int DEC_W  = 8;

  logic             clk;
  logic             rst_n;
  logic [DW-1:0]    ad_data;
  logic             arm, arm3;
  logic [DEC_W-1:0] decim;
  logic             fifo_full;
  logic             fifo_rst, wr_en, busy, done, overflow;
  logic [DW-1:0]    data_reg;
  logic             fifo_rst3, wr_en3, busy3, done3, overflow3;
  logic [DW-1:0]    data_reg3;

  int errors  = 0;
  int checks  = 0;
  int wr_seen = 0;
  bit prev_ovf = 1'b0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] d_arr[$];
  bit            fl[$];

  adc_frame_capture #(
    .DW(DW), .SETTLE_CYC(SETTLE), .SYNC_WORD(SYNC), .SYNC_LEN(2),
    .FRAME_LEN(FLEN), .DEC_W(DEC_W)
  ) u_dut (
    .ad0_clk_i(clk), .rst_ni(rst_n), .ad_data_i(ad_data), .arm_i(arm),
    .decim_i(decim), .fifo_full_i(fifo_full), .fifo_rst_o(fifo_rst),
    .data_reg_o(data_reg), .wr_en_o(wr_en), .busy_o(busy), .done_o(done),
    .overflow_o(overflow)
  );

  adc_frame_capture #(
    .DW(DW), .SETTLE_CYC(SETTLE), .SYNC_WORD(SYNC), .SYNC_LEN(3),
    .FRAME_LEN(FLEN3), .DEC_W(DEC_W)
  ) u_dut3 (
    .ad0_clk_i(clk), .rst_ni(rst_n), .ad_data_i(ad_data), .arm_i(arm3),
    .decim_i(decim), .fifo_full_i(fifo_full), .fifo_rst_o(fifo_rst3),
    .data_reg_o(data_reg3), .wr_en_o(wr_en3), .busy_o(busy3), .done_o(done3),
    .overflow_o(overflow3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every FIFO write is compared against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (wr_en === 1'b1) begin
          chk("wr_en_while_full", fifo_full, 0);
          chk("write_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            chk("write_data", data_reg, exp_q.pop_front());
            wr_seen++;
          end
        end
        if (wr_en3 === 1'b1) chk("wr_en3_while_full", fifo_full, 0);
      end
    end
  end

  // First index h at which d_arr[h-L+1..h] are all sync words (-1 if none).
  function automatic int find_hit(input int L);
    for (int h = L - 1; h < d_arr.size(); h++) begin
      bit all_sync;
      all_sync = 1'b1;
      for (int k = 0; k < L; k++)
        if (d_arr[h-k] != DW'(SYNC)) all_sync = 1'b0;
      if (all_sync) return h;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; arm = 1'b0; arm3 = 1'b0; fifo_full = 1'b0; ad_data = '0; decim = 8'd1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data_reg", data_reg, 0);
    chk("rst_wr_en",    wr_en,    0);
    chk("rst_fifo_rst", fifo_rst, 1);
    chk("rst_busy",     busy,     0);
    chk("rst_done",     done,     0);
    chk("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    prev_ovf = 1'b0;
    repeat (SETTLE + 1) @(posedge clk);
    #1;
  endtask

  // d_arr holds the hunt prefix (must contain a sync hit); the payload is
  // appended here. ramp_base<0 gives random payload. arm_mid=-2 means arm
  // on the done cycle. abort_at>=0 asserts reset mid-frame in that cycle.
  task automatic run_frame(input int dec, input int ramp_base, input int full_mode,
                           input bit use3, input int arm_mid, input int abort_at);
    int D, h, h3, np, mlast, i_done, i_done3, nw, w0, am, m;
    bit ovf;
    logic [DW-1:0] v;
    D       = (dec <= 1) ? 1 : dec;
    h       = find_hit(2);
    h3      = use3 ? find_hit(3) : -1;
    np      = d_arr.size();
    mlast   = (FLEN - 1) * D;
    i_done  = h + 3 + mlast;
    i_done3 = h3 + 3 + (FLEN3 - 1) * D;
    am      = (arm_mid == -2) ? i_done : arm_mid;
    while (d_arr.size() < i_done + 2) begin
      v = (ramp_base < 0) ? DW'($urandom) : DW'(ramp_base + d_arr.size() - np);
      d_arr.push_back(v);
    end
    fl.delete();
    for (int k = 0; k <= mlast; k++) begin
      case (full_mode)
        1:       fl.push_back($urandom_range(0, 4) == 0);
        2:       fl.push_back(k >= (FLEN / 2) * D && k < (FLEN / 2) * D + 3);
        default: fl.push_back(1'b0);
      endcase
    end
    // Reference: due samples are every D-th capture cycle; a due sample is
    // written unless the FIFO is full in that cycle.
    ovf = 1'b0; nw = 0;
    for (int k = 0; k <= mlast; k += D) begin
      if (!fl[k]) begin exp_q.push_back(d_arr[h + 1 + k]); nw++; end
      else ovf = 1'b1;
    end
    w0 = wr_seen;

    chk("overflow_hold", overflow, prev_ovf);
    @(posedge clk); #1;
    arm = 1'b1; arm3 = use3; ad_data = DW'(SYNC); decim = DEC_W'(dec); fifo_full = 1'b0;
    for (int i = 0; i <= i_done + 1; i++) begin
      @(posedge clk); #1;
      arm     = (i == am);
      arm3    = 1'b0;
      ad_data = d_arr[i];
      m       = i - 2 - h;
      if (m >= 0 && m <= mlast) fifo_full = fl[m];
      else if (m < 0)           fifo_full = 1'($urandom_range(0, 1));
      else                      fifo_full = 1'b0;
      if (i == abort_at) begin
        chk("wr_en_pre_reset", wr_en, (m >= 0) && (m % D == 0) && !fl[m]);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_wr_en",    wr_en,    0);
        chk("abort_busy",     busy,     0);
        chk("abort_fifo_rst", fifo_rst, 1);
        chk("abort_data_reg", data_reg, 0);
        exp_q.delete();
        do_reset();
        return;
      end
      @(negedge clk);
      chk("busy",     busy,     i < i_done);
      chk("fifo_rst", fifo_rst, i != h + 1);
      chk("done",     done,     i == i_done);
      chk("data_reg", data_reg, (i == 0) ? DW'(SYNC) : d_arr[i-1]);
      if (i == 0)          chk("overflow_cleared", overflow, 0);
      if (i == i_done + 1) chk("overflow_sticky",  overflow, ovf);
      if (use3) begin
        chk("fifo_rst3", fifo_rst3, i != h3 + 1);
        chk("done3",     done3,     i == i_done3);
        chk("busy3",     busy3,     i < i_done3);
        chk("data_reg3", data_reg3, (i == 0) ? DW'(SYNC) : d_arr[i-1]);
      end
    end
    chk("writes_left", exp_q.size(), 0);
    chk("write_count", wr_seen - w0, nw);
    if (use3) chk("overflow3", overflow3, 0);
    prev_ovf = ovf;
  endtask

  initial begin
    int dl[5];
    dl = '{0, 1, 2, 3, 7};
    rst_n = 1'b1; arm = 1'b0; arm3 = 1'b0; ad_data = '0; decim = 8'd1; fifo_full = 1'b0;
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    chk("por_fifo_rst", fifo_rst, 1);
    chk("por_busy",     busy,     0);
    chk("por_wr_en",    wr_en,    0);

    // Arm held from reset release: ignored during SETTLE, taken once IDLE.
    arm = 1'b1; rst_n = 1'b1;
    for (int k = 1; k <= SETTLE + 2; k++) begin
      @(posedge clk); #1;
      chk("settle_busy",  busy,  k > SETTLE);
      chk("settle_wr_en", wr_en, 0);
    end
    arm = 1'b0;
    do_reset();

    // Sync after a broken pair; first write is 10.
    d_arr = {8'd5, 8'd209, 8'd7, 8'd209, 8'd209};
    run_frame(1, 10, 0, 0, -1, -1);

    // Decimation by 4 over a ramp.
    d_arr = {8'd209, 8'd209};
    run_frame(4, 0, 0, 0, -1, -1);

    // FIFO full for 3 cycles mid-frame.
    d_arr = {8'd3, 8'd209, 8'd209};
    run_frame(1, -1, 2, 0, -1, -1);

    // SYNC_LEN=3 instance alongside; arm pulsed during capture.
    d_arr = {8'd209, 8'd209, 8'd8, 8'd209, 8'd209, 8'd209};
    run_frame(2, -1, 0, 1, 12, -1);

    // Randomised frames.
    for (int r = 0; r < 4; r++) begin
      d_arr.delete();
      repeat ($urandom_range(1, 8))
        d_arr.push_back(($urandom_range(0, 2) == 0) ? DW'(SYNC) : DW'($urandom));
      d_arr.push_back(DW'(SYNC));
      d_arr.push_back(DW'(SYNC));
      run_frame(dl[$urandom_range(0, 4)], -1, 1, 0, (r == 1) ? -2 : -1, -1);
    end

    // Reset mid-capture, then a full frame after rearm.
    d_arr = {8'd209, 8'd209};
    run_frame(1, -1, 0, 0, -1, 22);
    d_arr = {8'd1, 8'd209, 8'd209};
    run_frame(3, -1, 1, 0, -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
